// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel event counters plus a cycle counter, gated by CPU halt,
// with a snapshot shadow bank read out through a registered mux and sticky overflow flags.
module perf_counter_bank #(
    parameter int N_EV = 3,
    parameter int CW   = 32,
    parameter int SAT  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_EV-1:0] ev,
    input  logic            halt,
    input  logic            clr,
    input  logic            snap,
    input  logic [3:0]      rd_sel,
    output logic [CW-1:0]   rd_data,
    output logic [N_EV:0]   ovf,
    output logic            running
);

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            count_en;
    logic [N_EV:0]   inc;
    logic [N_EV:0]   ovf_q, ovf_d;
    logic [CW-1:0]   rd_data_q, rd_data_d;
    logic [CW-1:0]   cnt_q    [N_EV+1];
    logic [CW-1:0]   cnt_inc  [N_EV+1];
    logic [CW-1:0]   cnt_d    [N_EV+1];
    logic [CW-1:0]   shadow_q [N_EV+1];
    logic [CW-1:0]   shadow_d [N_EV+1];

    // The first halt cycle still counts; a stopped bank resumes counting on the cycle halt drops.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        case (state_q)
            RUN: begin
                count_en = 1'b1;
                if (halt) state_d = STOPPED;
            end
            STOPPED: begin
                if (!halt) begin
                    count_en = 1'b1;
                    state_d  = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (clr) begin
            state_d  = RUN;
            count_en = 1'b0;
        end
    end

    // Index N_EV is the cycle counter; a snap taken together with clr captures the pre-clear values.
    always_comb begin
        inc   = {1'b1, ev} & {(N_EV+1){count_en}};
        ovf_d = ovf_q;
        for (int i = 0; i <= N_EV; i++) begin
            cnt_inc[i] = cnt_q[i];
            if (inc[i]) begin
                if (&cnt_q[i]) begin
                    ovf_d[i]   = 1'b1;
                    cnt_inc[i] = (SAT != 0) ? cnt_q[i] : '0;
                end else begin
                    cnt_inc[i] = cnt_q[i] + CW'(1);
                end
            end
            cnt_d[i]    = clr ? '0 : cnt_inc[i];
            shadow_d[i] = snap ? (clr ? cnt_q[i] : cnt_inc[i]) : shadow_q[i];
        end
        if (clr) ovf_d = '0;
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i <= N_EV; i++) begin
            if (rd_sel == 4'(i)) rd_data_d = shadow_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            ovf_q     <= '0;
            rd_data_q <= '0;
            for (int i = 0; i <= N_EV; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ovf     = ovf_q;
    assign running = (state_q == RUN);

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter N_EV, default 3, number of event counter channels (1..15).
REQ-002 SHALL have parameter CW, default 32, width of every counter.
REQ-003 SHALL have parameter SAT, default 0, overflow mode: 0 wrap, 1 saturate.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ev  input  N_EV  per-channel event strobes, one count per high cycle.
REQ-007 SHALL have port halt  input  1  CPU halt level.
REQ-008 SHALL have port clr  input  1  synchronous clear pulse for counters, flags and FSM.
REQ-009 SHALL have port snap  input  1  snapshot pulse, copies live counters to shadow.
REQ-010 SHALL have port rd_sel  input  4  shadow readout index; 0..N_EV-1 event channels, N_EV cycle counter.
REQ-011 SHALL have port rd_data  output  CW  registered shadow value for rd_sel.
REQ-012 SHALL have port ovf  output  N_EV+1  sticky overflow flags; bit N_EV is the cycle counter.
REQ-013 SHALL have port running  output  1  high when the FSM is in RUN.

Function
REQ-014 SHALL contain N_EV event counters, one cycle counter and N_EV+1 shadow registers, all CW wide.
REQ-015 SHALL implement FSM states RUN and STOPPED.
REQ-016 RUN: cycle counter +1 every cycle; event counter i +1 on each cycle with ev[i]=1.
REQ-017 RUN -> STOPPED on the first cycle with halt=1; that cycle is counted (cycle counter +1, events counted) exactly once.
REQ-018 STOPPED: all live counters frozen; ev ignored; held halt adds no further counts.
REQ-019 STOPPED -> RUN on the first cycle with halt=0; counting resumes that cycle; values retained.
REQ-020 clr=1: all live counters 0, ovf all 0, FSM to RUN next cycle; no increment in the clr cycle; clr overrides ev, halt and overflow.
REQ-021 Wrap mode (SAT=0): an increment from 2^CW-1 gives 0 and sets the matching ovf bit.
REQ-022 Saturate mode (SAT=1): an increment at 2^CW-1 holds 2^CW-1 and sets the matching ovf bit.
REQ-023 ovf bits SHALL stay set until clr or rst.
REQ-024 snap=1: every shadow register loads the live counter value including this cycle's increment, visible next cycle.
REQ-025 snap and clr in the same cycle: shadows load the pre-clear register values with no increment; live counters then clear.
REQ-026 Shadow registers SHALL be affected only by snap and rst; clr SHALL NOT change them.
REQ-027 rd_data SHALL equal shadow[rd_sel] one cycle after rd_sel is applied.
REQ-028 rd_data SHALL be 0 for rd_sel > N_EV.
REQ-029 running SHALL be registered and equal 1 exactly when the FSM is in RUN.

Reset
REQ-030 rst=1 SHALL zero all live counters, shadows, ovf and rd_data, and set the FSM to RUN (running=1) on the next edge.
REQ-031 rst SHALL have priority over clr, snap, halt and ev.
REQ-032 Deasserting rst mid-run SHALL restart counting from 0 on the first cycle with rst=0.

Verification
REQ-033 Reset, then 10 cycles with halt=0, ev=3'b001 every cycle, then snap; rd_sel=3 -> 11; rd_sel=0 -> 11; rd_sel=1 -> 0.
REQ-034 halt rises at cycle 5 and is held 20 cycles, then snap; rd_sel=N_EV -> 5 and running=0; halt drops -> running=1 and the count resumes at 6.
REQ-035 CW=4, SAT=0, ev[0] held 17 cycles -> ch0=1 and ovf[0]=1. With SAT=1 under the same stimulus -> ch0=15 and ovf[0]=1.
REQ-036 Live ch0=7 with snap and clr in the same cycle and ev[0]=1 -> shadow ch0=7 and live ch0=0. A following snap gives ch0=0 and ovf=0.
REQ-037 rd_sel=9 with N_EV=3 -> rd_data=0. Change rd_sel -> rd_data updates one cycle later.
